// File: rtl/qu_common_pkg.sv
// Shared Qu core types: ROB geometry, entry state encoding, destination and cell layout.
// No logic; imported by the ROB and its lookup helper.
// Backpressure: not applicable.
package qu_common_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int DEST_WIDTH = 32;

    localparam logic [1:0] ROB_STATE_EMPTY   = 2'b00;
    localparam logic [1:0] ROB_STATE_RETIRED = 2'b01;
    localparam logic [1:0] ROB_STATE_EXECUTE = 2'b10;
    localparam logic [1:0] ROB_STATE_PENDING = 2'b11;

    typedef enum logic [1:0] {
        ROB_EMPTY   = ROB_STATE_EMPTY,
        ROB_RETIRED = ROB_STATE_RETIRED,
        ROB_EXECUTE = ROB_STATE_EXECUTE,
        ROB_PENDING = ROB_STATE_PENDING
    } rob_state_t;

    typedef logic [DEST_WIDTH-1:0]        dest_t;
    typedef logic [$clog2(ROB_DEPTH)-1:0] rob_addr_t;

    typedef struct packed {
        rob_state_t  state;
        logic        mispredicted_branch;
        logic        load;
        logic        store;
        dest_t       dest;
        logic [31:0] value;
    } rob_cell_t;

    // Entry is allocated and still waiting for its CDB result.
    function automatic logic rob_in_flight(input rob_state_t s);
        return (s == ROB_PENDING) || (s == ROB_EXECUTE);
    endfunction

endpackage

// File: rtl/qu_rob_lookup.sv
// Operand lookup: reads one ROB entry by tag, forwarding a same-cycle CDB writeback.
// Latency: combinational.
// Backpressure: none; value is zero whenever ready is low.
module qu_rob_lookup
    import qu_common_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int VALUE_WIDTH = 32
) (
    input  rob_state_t                 state_i [DEPTH],
    input  logic [VALUE_WIDTH-1:0]     value_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   tag_i,
    input  logic                       wb_valid_i,
    input  logic [$clog2(DEPTH)-1:0]   wb_tag_i,
    input  logic [VALUE_WIDTH-1:0]     wb_value_i,
    output logic                       ready_o,
    output logic [VALUE_WIDTH-1:0]     value_o
);

    always_comb begin
        ready_o = 1'b0;
        value_o = '0;
        if (wb_valid_i && (wb_tag_i == tag_i) && rob_in_flight(state_i[tag_i])) begin
            ready_o = 1'b1;
            value_o = wb_value_i;
        end else if (state_i[tag_i] == ROB_RETIRED) begin
            ready_o = 1'b1;
            value_o = value_i[tag_i];
        end
    end

endmodule

// File: rtl/qu_rob_n.sv
// Parametrised reorder buffer: in-order allocate/commit, out-of-order writeback, full flush on mispredict.
// Latency: writeback visible at commit next cycle; operand lookup bypasses same cycle; flush_o one cycle after commit.
// Backpressure: alloc_ready_o low when full or a mispredicted head is committable; commit waits on commit_ready_i.
module qu_rob_n
    import qu_common_pkg::*;
#(
    parameter  int DEPTH       = ROB_DEPTH,
    parameter  int VALUE_WIDTH = 32,
    localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_valid_i,
    output logic                   alloc_ready_o,
    input  logic [31:0]            alloc_dest_i,
    input  logic                   alloc_load_i,
    input  logic                   alloc_store_i,
    output logic [ADDR_WIDTH-1:0]  alloc_tag_o,
    input  logic                   exec_valid_i,
    input  logic [ADDR_WIDTH-1:0]  exec_tag_i,
    input  logic                   wb_valid_i,
    input  logic [ADDR_WIDTH-1:0]  wb_tag_i,
    input  logic [VALUE_WIDTH-1:0] wb_value_i,
    input  logic                   wb_mispredict_i,
    input  logic [ADDR_WIDTH-1:0]  qj_tag_i,
    input  logic [ADDR_WIDTH-1:0]  qk_tag_i,
    output logic                   qj_ready_o,
    output logic                   qk_ready_o,
    output logic [VALUE_WIDTH-1:0] qj_value_o,
    output logic [VALUE_WIDTH-1:0] qk_value_o,
    output logic                   commit_valid_o,
    input  logic                   commit_ready_i,
    output logic [ADDR_WIDTH-1:0]  commit_tag_o,
    output logic [VALUE_WIDTH-1:0] commit_value_o,
    output logic [31:0]            commit_dest_o,
    output logic                   commit_load_o,
    output logic                   commit_store_o,
    output logic                   flush_o,
    output logic [ADDR_WIDTH:0]    count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    typedef struct packed {
        rob_state_t             state;
        logic                   mispredicted_branch;
        logic                   load;
        logic                   store;
        dest_t                  dest;
        logic [VALUE_WIDTH-1:0] value;
    } cell_t;

    cell_t                  rob_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  head_q;
    logic [ADDR_WIDTH-1:0]  tail_q;
    logic [ADDR_WIDTH:0]    count_q;
    logic                   flush_q;

    rob_state_t             state_w [DEPTH];
    logic [VALUE_WIDTH-1:0] value_w [DEPTH];
    cell_t                  head_cell;
    logic                   alloc_fire;
    logic                   commit_fire;
    logic                   flush_req;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_w[i] = rob_q[i].state;
            value_w[i] = rob_q[i].value;
        end
    end

    assign head_cell      = rob_q[head_q];
    assign commit_valid_o = (head_cell.state == ROB_RETIRED);
    assign commit_tag_o   = head_q;
    assign commit_value_o = head_cell.value;
    assign commit_dest_o  = head_cell.dest;
    assign commit_load_o  = head_cell.load;
    assign commit_store_o = head_cell.store;

    assign full_o        = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign flush_o       = flush_q;
    assign alloc_tag_o   = tail_q;
    // Freeze dispatch while a mispredicted head can retire so the flush cannot swallow a new entry.
    assign alloc_ready_o = !full_o && !(commit_valid_o && head_cell.mispredicted_branch);

    assign alloc_fire  = alloc_valid_i && alloc_ready_o;
    assign commit_fire = commit_valid_o && commit_ready_i;
    assign flush_req   = commit_fire && head_cell.mispredicted_branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_req;
            if (flush_req) begin
                for (int i = 0; i < DEPTH; i++) begin
                    rob_q[i].state <= ROB_EMPTY;
                end
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (exec_valid_i && (rob_q[exec_tag_i].state == ROB_PENDING)) begin
                    rob_q[exec_tag_i].state <= ROB_EXECUTE;
                end
                // Placed after the exec mark so a same-tag writeback overrides it.
                if (wb_valid_i && rob_in_flight(rob_q[wb_tag_i].state)) begin
                    rob_q[wb_tag_i].state               <= ROB_RETIRED;
                    rob_q[wb_tag_i].value               <= wb_value_i;
                    rob_q[wb_tag_i].mispredicted_branch <= wb_mispredict_i;
                end
                if (alloc_fire) begin
                    rob_q[tail_q] <= '{state:               ROB_PENDING,
                                       mispredicted_branch: 1'b0,
                                       load:                alloc_load_i,
                                       store:               alloc_store_i,
                                       dest:                alloc_dest_i,
                                       value:               '0};
                    tail_q <= tail_q + 1'b1;
                end
                if (commit_fire) begin
                    rob_q[head_q].state <= ROB_EMPTY;
                    head_q              <= head_q + 1'b1;
                end
                case ({alloc_fire, commit_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    qu_rob_lookup #(.DEPTH(DEPTH), .VALUE_WIDTH(VALUE_WIDTH)) u_lookup_qj (
        .state_i    (state_w),
        .value_i    (value_w),
        .tag_i      (qj_tag_i),
        .wb_valid_i (wb_valid_i),
        .wb_tag_i   (wb_tag_i),
        .wb_value_i (wb_value_i),
        .ready_o    (qj_ready_o),
        .value_o    (qj_value_o)
    );

    qu_rob_lookup #(.DEPTH(DEPTH), .VALUE_WIDTH(VALUE_WIDTH)) u_lookup_qk (
        .state_i    (state_w),
        .value_i    (value_w),
        .tag_i      (qk_tag_i),
        .wb_valid_i (wb_valid_i),
        .wb_tag_i   (wb_tag_i),
        .wb_value_i (wb_value_i),
        .ready_o    (qk_ready_o),
        .value_o    (qk_value_o)
    );

endmodule

// File: tb/tb_qu_rob_n.sv
// Directed bench for qu_rob_n (DEPTH=8): allocation, ordered commit, bypass, flush, wrap and reset.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_qu_rob_n;

    localparam int DEPTH = 8;
    localparam int VW    = 32;
    localparam int AW    = 3;

    logic          clk;
    logic          rst_n;
    logic          alloc_valid_i;
    logic          alloc_ready_o;
    logic [31:0]   alloc_dest_i;
    logic          alloc_load_i;
    logic          alloc_store_i;
    logic [AW-1:0] alloc_tag_o;
    logic          exec_valid_i;
    logic [AW-1:0] exec_tag_i;
    logic          wb_valid_i;
    logic [AW-1:0] wb_tag_i;
    logic [VW-1:0] wb_value_i;
    logic          wb_mispredict_i;
    logic [AW-1:0] qj_tag_i;
    logic [AW-1:0] qk_tag_i;
    logic          qj_ready_o;
    logic          qk_ready_o;
    logic [VW-1:0] qj_value_o;
    logic [VW-1:0] qk_value_o;
    logic          commit_valid_o;
    logic          commit_ready_i;
    logic [AW-1:0] commit_tag_o;
    logic [VW-1:0] commit_value_o;
    logic [31:0]   commit_dest_o;
    logic          commit_load_o;
    logic          commit_store_o;
    logic          flush_o;
    logic [AW:0]   count_o;
    logic          full_o;
    logic          empty_o;

    int checks = 0;
    int errors = 0;

    qu_rob_n #(.DEPTH(DEPTH), .VALUE_WIDTH(VW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_ready_o   (alloc_ready_o),
        .alloc_dest_i    (alloc_dest_i),
        .alloc_load_i    (alloc_load_i),
        .alloc_store_i   (alloc_store_i),
        .alloc_tag_o     (alloc_tag_o),
        .exec_valid_i    (exec_valid_i),
        .exec_tag_i      (exec_tag_i),
        .wb_valid_i      (wb_valid_i),
        .wb_tag_i        (wb_tag_i),
        .wb_value_i      (wb_value_i),
        .wb_mispredict_i (wb_mispredict_i),
        .qj_tag_i        (qj_tag_i),
        .qk_tag_i        (qk_tag_i),
        .qj_ready_o      (qj_ready_o),
        .qk_ready_o      (qk_ready_o),
        .qj_value_o      (qj_value_o),
        .qk_value_o      (qk_value_o),
        .commit_valid_o  (commit_valid_o),
        .commit_ready_i  (commit_ready_i),
        .commit_tag_o    (commit_tag_o),
        .commit_value_o  (commit_value_o),
        .commit_dest_o   (commit_dest_o),
        .commit_load_o   (commit_load_o),
        .commit_store_o  (commit_store_o),
        .flush_o         (flush_o),
        .count_o         (count_o),
        .full_o          (full_o),
        .empty_o         (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_tag;

        rst_n = 1'b0;
        alloc_valid_i = 1'b0; alloc_dest_i = '0; alloc_load_i = 1'b0; alloc_store_i = 1'b0;
        exec_valid_i = 1'b0; exec_tag_i = '0;
        wb_valid_i = 1'b0; wb_tag_i = '0; wb_value_i = '0; wb_mispredict_i = 1'b0;
        qj_tag_i = '0; qk_tag_i = '0; commit_ready_i = 1'b0;
        #3;
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_alloc_rdy", alloc_ready_o, 1);
        chk("rst_alloc_tag", alloc_tag_o, 0);
        chk("rst_commit_vld", commit_valid_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_qj_rdy", qj_ready_o, 0);
        chk("rst_qk_rdy", qk_ready_o, 0);
        #4 rst_n = 1'b1;
        cyc();

        // Fill all eight entries, then a ninth request must be held off.
        for (int i = 0; i < 8; i++) begin
            alloc_valid_i = 1'b1; alloc_dest_i = 32'h100 + i;
            alloc_load_i = (i == 3); alloc_store_i = (i == 5);
            #1;
            chk("fill_tag", alloc_tag_o, i);
            chk("fill_rdy", alloc_ready_o, 1);
            cyc();
        end
        alloc_load_i = 1'b0; alloc_store_i = 1'b0;
        #1;
        chk("full_flag", full_o, 1);
        chk("full_count", count_o, 8);
        chk("full_alloc_rdy", alloc_ready_o, 0);
        cyc();
        chk("ninth_refused_count", count_o, 8);
        chk("ninth_refused_tail", alloc_tag_o, 0);
        alloc_valid_i = 1'b0;

        // Out-of-order writebacks 2,0,1 commit in order 0,1,2.
        commit_ready_i = 1'b1;
        wb_valid_i = 1'b1; wb_tag_i = 3'd2; wb_value_i = 32'h22;
        #1 chk("wb2_no_commit", commit_valid_o, 0);
        cyc();
        wb_tag_i = 3'd0; wb_value_i = 32'h0;
        #1 chk("wb_head_not_same_cycle", commit_valid_o, 0);
        cyc();
        wb_tag_i = 3'd1; wb_value_i = 32'h11;
        #1;
        chk("c0_vld", commit_valid_o, 1);
        chk("c0_tag", commit_tag_o, 0);
        chk("c0_val", commit_value_o, 32'h0);
        chk("c0_dest", commit_dest_o, 32'h100);
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("c1_vld", commit_valid_o, 1);
        chk("c1_tag", commit_tag_o, 1);
        chk("c1_val", commit_value_o, 32'h11);
        cyc();
        chk("c2_vld", commit_valid_o, 1);
        chk("c2_tag", commit_tag_o, 2);
        chk("c2_val", commit_value_o, 32'h22);
        chk("c2_dest", commit_dest_o, 32'h102);
        cyc();
        chk("c3_pending", commit_valid_o, 0);
        chk("after3_count", count_o, 5);
        commit_ready_i = 1'b0;

        // Same-cycle bypass on qj; qk looks at a pending entry.
        wb_valid_i = 1'b1; wb_tag_i = 3'd3; wb_value_i = 32'hABCD;
        qj_tag_i = 3'd3; qk_tag_i = 3'd4;
        #1;
        chk("byp_qj_rdy", qj_ready_o, 1);
        chk("byp_qj_val", qj_value_o, 32'hABCD);
        chk("byp_qk_rdy", qk_ready_o, 0);
        chk("byp_qk_val", qk_value_o, 0);
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("stored_qj_rdy", qj_ready_o, 1);
        chk("stored_qj_val", qj_value_o, 32'hABCD);
        chk("c3_load", commit_load_o, 1);
        wb_valid_i = 1'b1; wb_value_i = 32'h5555;
        #1 chk("no_overwrite_lookup", qj_value_o, 32'hABCD);
        cyc();
        wb_valid_i = 1'b0; commit_ready_i = 1'b1;
        #1 chk("no_overwrite_commit", commit_value_o, 32'hABCD);
        cyc();
        commit_ready_i = 1'b0;

        // Exec and writeback to the same tag: writeback wins.
        exec_valid_i = 1'b1; exec_tag_i = 3'd4;
        wb_valid_i = 1'b1; wb_tag_i = 3'd4; wb_value_i = 32'h44;
        cyc();
        exec_tag_i = 3'd5; wb_valid_i = 1'b0;
        #1;
        chk("exwb_vld", commit_valid_o, 1);
        chk("exwb_tag", commit_tag_o, 4);
        chk("exwb_val", commit_value_o, 32'h44);
        cyc();
        exec_valid_i = 1'b0; qk_tag_i = 3'd5;
        #1 chk("exec_not_ready", qk_ready_o, 0);

        // Refill to full, then commit and allocate in the same cycle.
        for (int i = 0; i < 4; i++) begin
            alloc_valid_i = 1'b1; alloc_dest_i = 32'h200 + i;
            #1 chk("refill_tag", alloc_tag_o, i);
            cyc();
        end
        alloc_valid_i = 1'b0;
        #1;
        chk("refull_flag", full_o, 1);
        chk("refull_count", count_o, 8);
        commit_ready_i = 1'b1; alloc_valid_i = 1'b1; alloc_dest_i = 32'h204;
        #1;
        chk("full_both_alloc_rdy", alloc_ready_o, 0);
        chk("full_both_commit_vld", commit_valid_o, 1);
        chk("full_both_commit_tag", commit_tag_o, 4);
        cyc();
        commit_ready_i = 1'b0;
        #1;
        chk("after_commit_count", count_o, 7);
        chk("after_commit_alloc_rdy", alloc_ready_o, 1);
        chk("after_commit_alloc_tag", alloc_tag_o, 4);
        cyc();
        alloc_valid_i = 1'b0;
        #1;
        chk("realloc_count", count_o, 8);
        chk("realloc_full", full_o, 1);

        rst_n = 1'b0;
        #1;
        chk("midrst_empty", empty_o, 1);
        chk("midrst_count", count_o, 0);
        cyc();
        rst_n = 1'b1;
        #1;

        // Mispredicted branch at tag 1 flushes the buffer.
        for (int i = 0; i < 4; i++) begin
            alloc_valid_i = 1'b1; alloc_dest_i = 32'h300 + i;
            #1 chk("fl_alloc_tag", alloc_tag_o, i);
            cyc();
        end
        alloc_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_tag_i = 3'd0; wb_value_i = 32'h10;
        cyc();
        wb_tag_i = 3'd1; wb_value_i = 32'h11; wb_mispredict_i = 1'b1;
        cyc();
        wb_valid_i = 1'b0; wb_mispredict_i = 1'b0; commit_ready_i = 1'b1;
        #1;
        chk("fl_c0_tag", commit_tag_o, 0);
        chk("fl_c0_alloc_rdy", alloc_ready_o, 1);
        chk("fl_c0_flush", flush_o, 0);
        cyc();
        alloc_valid_i = 1'b1; alloc_dest_i = 32'h3FF;
        wb_valid_i = 1'b1; wb_tag_i = 3'd2; wb_value_i = 32'h22;
        #1;
        chk("fl_c1_vld", commit_valid_o, 1);
        chk("fl_c1_tag", commit_tag_o, 1);
        chk("fl_c1_alloc_rdy", alloc_ready_o, 0);
        chk("fl_c1_flush", flush_o, 0);
        cyc();
        wb_valid_i = 1'b0; commit_ready_i = 1'b0;
        #1;
        chk("fl_pulse", flush_o, 1);
        chk("fl_count", count_o, 0);
        chk("fl_empty", empty_o, 1);
        chk("fl_commit_vld", commit_valid_o, 0);
        chk("fl_alloc_tag", alloc_tag_o, 0);
        chk("fl_alloc_rdy", alloc_ready_o, 1);
        cyc();
        alloc_valid_i = 1'b0; qj_tag_i = 3'd2;
        #1;
        chk("fl_pulse_end", flush_o, 0);
        chk("fl_post_count", count_o, 1);
        chk("fl_no_stale_commit", commit_valid_o, 0);
        chk("fl_wb_discarded", qj_ready_o, 0);

        wb_valid_i = 1'b1; wb_tag_i = 3'd0; wb_value_i = 32'h77;
        cyc();
        wb_valid_i = 1'b0; commit_ready_i = 1'b1;
        #1;
        chk("pre_wrap_tag", commit_tag_o, 0);
        chk("pre_wrap_val", commit_value_o, 32'h77);
        cyc();
        commit_ready_i = 1'b0;
        #1 chk("pre_wrap_empty", empty_o, 1);

        // Twenty alloc/writeback/commit rounds wrap the pointers through 7 -> 0.
        for (int k = 0; k < 20; k++) begin
            exp_tag = (1 + k) % 8;
            alloc_valid_i = 1'b1; alloc_dest_i = 32'h400 + k;
            #1 chk("wrap_alloc_tag", alloc_tag_o, exp_tag);
            cyc();
            alloc_valid_i = 1'b0;
            wb_valid_i = 1'b1; wb_tag_i = exp_tag[AW-1:0]; wb_value_i = 32'h1000 + k;
            cyc();
            wb_valid_i = 1'b0; commit_ready_i = 1'b1;
            #1;
            chk("wrap_commit_tag", commit_tag_o, exp_tag);
            chk("wrap_commit_val", commit_value_o, 32'h1000 + k);
            cyc();
            commit_ready_i = 1'b0;
        end
        #1;
        chk("wrap_end_empty", empty_o, 1);
        chk("wrap_end_tail", alloc_tag_o, 5);

        // Reset with five entries, two retired.
        for (int i = 0; i < 5; i++) begin
            alloc_valid_i = 1'b1; alloc_dest_i = 32'h500 + i;
            #1 chk("r6_alloc_tag", alloc_tag_o, (5 + i) % 8);
            cyc();
        end
        alloc_valid_i = 1'b0;
        wb_valid_i = 1'b1; wb_tag_i = 3'd5; wb_value_i = 32'h55;
        cyc();
        wb_tag_i = 3'd6; wb_value_i = 32'h66;
        cyc();
        wb_valid_i = 1'b0;
        #1;
        chk("r6_pre_vld", commit_valid_o, 1);
        chk("r6_pre_count", count_o, 5);
        rst_n = 1'b0;
        #1;
        chk("r6_commit_vld", commit_valid_o, 0);
        chk("r6_empty", empty_o, 1);
        chk("r6_count", count_o, 0);
        chk("r6_flush", flush_o, 0);
        chk("r6_alloc_tag", alloc_tag_o, 0);
        cyc();
        chk("r6_flush_held", flush_o, 0);
        rst_n = 1'b1;
        cyc();
        chk("r6_flush_after", flush_o, 0);
        chk("r6_empty_after", empty_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qu_rob_n.md
Name: qu_rob_n

Overview:
- Parametrised reorder buffer for the Qu out-of-order core; successor to the fixed 8-entry ROB cell layout.
- Sits between dispatch (allocation), the common data bus (writeback) and the commit stage (register/dmem update).
- Adds the following, all configurable:
  - depth
  - dual operand lookup with same-cycle writeback bypass
  - per-entry state tracking
  - full flush on commit of a mispredicted branch

Parameters:
- DEPTH, 8: entry count; power of two, ≥2.
- VALUE_WIDTH, 32: result value width.
- ADDR_WIDTH, $clog2(DEPTH): tag/pointer width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  dispatch requests an entry
- alloc_ready_o  out  1  entry can be accepted this cycle
- alloc_dest_i  in  32  dest_t (phys reg padded or dmem address)
- alloc_load_i  in  1  entry is a load
- alloc_store_i  in  1  entry is a store
- alloc_tag_o  out  ADDR_WIDTH  tag of entry being allocated (= tail)
- exec_valid_i  in  1  entry issued to a functional unit
- exec_tag_i  in  ADDR_WIDTH  issued entry tag
- wb_valid_i  in  1  CDB writeback
- wb_tag_i  in  ADDR_WIDTH  writeback tag
- wb_value_i  in  VALUE_WIDTH  result
- wb_mispredict_i  in  1  branch resolved mispredicted
- qj_tag_i, qk_tag_i  in  ADDR_WIDTH  operand lookup tags
- qj_ready_o, qk_ready_o  out  1  operand value available
- qj_value_o, qk_value_o  out  VALUE_WIDTH  operand value
- commit_valid_o  out  1  head entry completed
- commit_ready_i  in  1  commit stage accepts head
- commit_tag_o  out  ADDR_WIDTH  head tag
- commit_value_o  out  VALUE_WIDTH  head value
- commit_dest_o  out  32  head dest
- commit_load_o, commit_store_o  out  1  head type flags
- flush_o  out  1  one-cycle pulse: pipeline flush
- count_o  out  ADDR_WIDTH+1  occupied entries
- full_o, empty_o  out  1  status

Behaviour:
- Storage: DEPTH × rob_cell_t. State encodings:
  - EMPTY 00
  - RETIRED 01 (result present)
  - EXECUTE 10
  - PENDING 11
- Reset (async, rst_n low):
  - all states EMPTY; head=tail=0; count=0.
  - outputs: flush_o=0, commit_valid_o=0, empty_o=1, full_o=0, alloc_ready_o=1, alloc_tag_o=0, qj/qk_ready_o=0.
  - Reset mid-operation discards all entries immediately.
- Allocation:
  - fire = alloc_valid_i & alloc_ready_o.
  - On fire, entry[tail] gets: dest, load, store, mispredicted_branch=0, value=0, state=PENDING; tail+1 mod DEPTH.
  - alloc_ready_o = !full_o & !(commit_valid_o & head.mispredicted_branch).
  - No full-bypass: a slot freed by commit becomes allocatable next cycle.
- Exec mark: exec_valid_i sets state PENDING→EXECUTE; ignored in any other state.
- Writeback:
  - wb_valid_i on an entry in PENDING or EXECUTE writes value and mispredicted_branch=wb_mispredict_i; state→RETIRED.
  - Writeback to EMPTY or RETIRED entries is ignored (no overwrite).
  - Same-cycle exec and wb on the same tag: wb wins.
- Lookup (combinational):
  - qX_ready_o=1 if entry[qX_tag_i] is RETIRED, or if wb_valid_i & wb_tag_i==qX_tag_i targets a PENDING/EXECUTE entry.
  - In the bypass case qX_value_o = wb_value_i. Otherwise value = stored value; when not ready, value is 0.
- Commit:
  - commit_valid_o = (entry[head].state==RETIRED); commit_* fields are driven from entry[head].
  - Writeback to the head is visible at commit no earlier than the next cycle (registered).
  - On commit_valid_o & commit_ready_i: entry[head]→EMPTY, head+1.
- Flush:
  - Triggered by a commit handshake where head.mispredicted_branch=1.
  - Effect: all entries EMPTY, head=tail=0, count=0; flush_o=1 the following cycle only.
  - alloc_ready_o is low during the flush-commit cycle, so no allocation is lost. Same-cycle exec/wb to other entries is discarded.
- Count and status:
  - count updates +1 on alloc only, −1 on commit only, unchanged on both.
  - full_o = (count==DEPTH); empty_o = (count==0).
- Pointers wrap mod DEPTH. Tags are only valid while their entry is occupied.

Decomposition:
- Additions to the qu_common package:
  - generalise ROB_DEPTH use
  - add rob_state_t enum mirroring the ROB_STATE_* constants
  - reuse rob_cell_t, dest_t, rob_addr_t
- Sub-module: qu_rob_lookup (combinational tag read + writeback bypass), instantiated twice (qj, qk).

Test Plan:
1. Reset, then allocate 8 entries with DEPTH=8 → tags 0..7, full_o=1, count_o=8, alloc_ready_o=0; 9th request not accepted.
2. wb tags 2,0,1 with values 0x22,0x00,0x11, commit_ready_i=1 → commits in order 0,1,2 with those values; tag 2 commits one cycle after tag 1.
3. Same-cycle wb tag 3 value 0xABCD and qj_tag_i=3 → qj_ready_o=1, qj_value_o=0xABCD that cycle.
4. Allocate 4, wb tag1 with wb_mispredict_i=1, commit tags 0,1 → flush_o pulses once after tag-1 commit; count_o=0, empty_o=1; tags 2,3 never commit; next allocation returns tag 0.
5. Full buffer: commit and allocation requested in the same cycle → commit occurs, alloc is refused that cycle and accepted the next; count stays ≤8. Pointers wrap 7→0 correctly over 20 alloc/commit cycles.
6. rst_n asserted low with 5 entries, 2 of them RETIRED → immediately commit_valid_o=0, empty_o=1; no flush_o pulse.
